// File: rtl/sprite_rom_arbiter_if.sv
// Sprite ROM arbiter bus: requester handshake, ROM address/data and read return.
// master = draw engines + ROM side, slave = arbiter.
interface sprite_rom_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 9,
  parameter int DATA_W  = 3
);
  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ-1:0]        req_lock;
  logic [NUM_REQ-1:0]        gnt;
  logic [ADDR_W-1:0]         rom_address;
  logic [DATA_W-1:0]         rom_q;
  logic [NUM_REQ-1:0]        rd_valid;
  logic [DATA_W-1:0]         rd_data;
  logic                      busy;

  modport master (
    output req, req_addr, req_lock, rom_q,
    input  gnt, rom_address, rd_valid, rd_data, busy
  );

  modport slave (
    input  req, req_addr, req_lock, rom_q,
    output gnt, rom_address, rd_valid, rd_data, busy
  );
endinterface

// File: rtl/sprite_rom_arbiter.sv
// Round-robin arbiter sharing one registered sprite ROM among NUM_REQ requesters.
// Ports: vga_clk, reset (sync, active-high), bus (slave modport: req/req_addr/
// req_lock/rom_q in; gnt/rom_address/rd_valid/rd_data/busy out).
// Optional: define SPRITE_ARB_PRIO0_EN to give requester 0 absolute priority in ARB.
module sprite_rom_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 9,
  parameter int DATA_W  = 3,
  parameter int ROM_LAT = 1
) (
  input logic                vga_clk,
  input logic                reset,
  sprite_rom_arbiter_if.slave bus
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic {
    ARB,
    LOCKED
  } state_e;

  state_e            state_q, state_d;
  logic [IW-1:0]     owner_q, owner_d;
  logic [IW-1:0]     rr_ptr_q, rr_ptr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;

  logic              hit;
  logic [IW-1:0]     win;
  logic [NUM_REQ-1:0] gnt;

  logic [ROM_LAT-1:0] vld_q;
  logic [NUM_REQ-1:0] tag_q [ROM_LAT];

  function automatic logic [IW-1:0] inc(
    input logic [IW-1:0] v
  );
    inc = (v == IW'(NUM_REQ - 1)) ? '0 : v + 1'b1;
  endfunction

  // Winner select. Search order starts at rr_ptr and wraps.
  always_comb begin : pick
    int idx;
    hit = 1'b0;
    win = '0;
    idx = 0;
    if (!reset) begin
      if (state_q == LOCKED) begin
        hit = bus.req[owner_q];
        win = owner_q;
      end else begin
`ifdef SPRITE_ARB_PRIO0_EN
        if (bus.req[0]) begin
          hit = 1'b1;
          win = '0;
        end
`endif
        for (int k = 0; k < NUM_REQ; k++) begin
          idx = (int'(rr_ptr_q) + k) % NUM_REQ;
          if (!hit && bus.req[idx]) begin
            hit = 1'b1;
            win = IW'(idx);
          end
        end
      end
    end
    gnt = hit ? (NUM_REQ'(1) << win) : '0;
  end

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    rr_ptr_d = rr_ptr_q;
    addr_d   = addr_q;
    if (hit) begin
      addr_d = bus.req_addr[int'(win)*ADDR_W +: ADDR_W];
    end
    unique case (state_q)
      ARB: begin
        if (hit) begin
`ifdef SPRITE_ARB_PRIO0_EN
          // Priority grants to 0 leave the rotation untouched.
          if (win != '0) rr_ptr_d = inc(win);
`else
          rr_ptr_d = inc(win);
`endif
          if (bus.req_lock[win]) begin
            state_d = LOCKED;
            owner_d = win;
          end
        end
      end
      LOCKED: begin
        if (!bus.req_lock[owner_q]) begin
          state_d  = ARB;
          rr_ptr_d = inc(owner_q);
        end
      end
      default: state_d = ARB;
    endcase
  end

  always_ff @(posedge vga_clk) begin
    if (reset) begin
      state_q  <= ARB;
      owner_q  <= '0;
      rr_ptr_q <= '0;
      addr_q   <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      rr_ptr_q <= rr_ptr_d;
      addr_q   <= addr_d;
    end
  end

  // Return tag pipeline, aligned with the ROM read latency.
  always_ff @(posedge vga_clk) begin
    if (reset) begin
      vld_q <= '0;
      for (int i = 0; i < ROM_LAT; i++) tag_q[i] <= '0;
    end else begin
      vld_q[0] <= hit;
      tag_q[0] <= gnt;
      for (int i = 1; i < ROM_LAT; i++) begin
        vld_q[i] <= vld_q[i-1];
        tag_q[i] <= tag_q[i-1];
      end
    end
  end

  assign bus.gnt         = gnt;
  assign bus.rom_address = addr_d;
  // Reads still in flight while reset is high are dropped, tail included.
  assign bus.rd_valid    = (vld_q[ROM_LAT-1] && !reset)
                         ? tag_q[ROM_LAT-1] : '0;
  assign bus.rd_data     = bus.rom_q;
  assign bus.busy        = (|vld_q) || (state_q == LOCKED);

endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// Testbench for sprite_rom_arbiter: vector table, corner sequences, random vs model.
// Works with or without SPRITE_ARB_PRIO0_EN defined.
module tb_sprite_rom_arbiter;

  localparam int N   = 4;
  localparam int A   = 9;
  localparam int D   = 3;
  localparam int LAT = 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sprite_rom_arbiter_if #(.NUM_REQ(N), .ADDR_W(A), .DATA_W(D)) bus ();

  sprite_rom_arbiter #(
    .NUM_REQ(N), .ADDR_W(A), .DATA_W(D), .ROM_LAT(LAT)
  ) u_dut (
    .vga_clk (clk),
    .reset   (rst),
    .bus     (bus)
  );

  logic [D-1:0] rom [1<<A];
  logic [D-1:0] rpipe [LAT];

  always @(posedge clk) begin
    rpipe[0] <= rom[bus.rom_address];
    for (int i = 1; i < LAT; i++) rpipe[i] <= rpipe[i-1];
  end
  assign bus.rom_q = rpipe[LAT-1];

  int n_vec = 0;
  int n_bad = 0;

  logic [A-1:0] addr_arr [N];

  // Reference model state
  int           m_ptr;
  int           m_own;
  int           m_g;
  logic [A-1:0] m_last;
  int           qtag [$];
  logic [A-1:0] qaddr [$];

  logic [N-1:0] exp_gnt, exp_rv;
  logic [A-1:0] exp_addr;
  logic [D-1:0] exp_data;
  logic         exp_busy;

  typedef struct {
    logic         r;
    logic [N-1:0] req;
    logic [N-1:0] lock;
    logic [N-1:0] gnt;
    logic [N-1:0] rv;
    logic         busy;
    logic [A-1:0] addr;
  } vec_t;

  vec_t vt [$];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h want=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_eval();
    int t;
    m_g = -1;
    if (!rst) begin
      if (m_own >= 0) begin
        if (bus.req[m_own]) m_g = m_own;
      end else begin
`ifdef SPRITE_ARB_PRIO0_EN
        if (bus.req[0]) m_g = 0;
`endif
        for (int k = 0; k < N; k++)
          if (m_g < 0 && bus.req[(m_ptr+k)%N]) m_g = (m_ptr + k) % N;
      end
    end
    exp_gnt  = (m_g >= 0) ? (N'(1) << m_g) : '0;
    exp_addr = (m_g >= 0) ? addr_arr[m_g] : m_last;
    t        = qtag[LAT-1];
    exp_rv   = (!rst && t >= 0) ? (N'(1) << t) : '0;
    exp_data = rom[qaddr[LAT-1]];
    exp_busy = (m_own >= 0);
    foreach (qtag[i]) if (qtag[i] >= 0) exp_busy = 1'b1;
  endtask

  task automatic model_update();
    if (rst) begin
      m_ptr  = 0;
      m_own  = -1;
      m_last = '0;
      foreach (qtag[i]) qtag[i] = -1;
    end else begin
      qtag.push_front(m_g);
      qaddr.push_front((m_g >= 0) ? addr_arr[m_g] : '0);
      void'(qtag.pop_back());
      void'(qaddr.pop_back());
      if (m_g >= 0) m_last = addr_arr[m_g];
      if (m_own >= 0) begin
        if (!bus.req_lock[m_own]) begin
          m_ptr = (m_own + 1) % N;
          m_own = -1;
        end
      end else if (m_g >= 0) begin
`ifdef SPRITE_ARB_PRIO0_EN
        if (m_g != 0) m_ptr = (m_g + 1) % N;
`else
        m_ptr = (m_g + 1) % N;
`endif
        if (bus.req_lock[m_g]) m_own = m_g;
      end
    end
  endtask

  task automatic apply(input logic r, input logic [N-1:0] rq,
                       input logic [N-1:0] lk);
    rst          = r;
    bus.req      = rq;
    bus.req_lock = lk;
    for (int i = 0; i < N; i++) bus.req_addr[i*A +: A] = addr_arr[i];
    #1;
    model_eval();
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic add(input logic r, input logic [N-1:0] rq,
                     input logic [N-1:0] lk, input logic [N-1:0] g,
                     input logic [N-1:0] rv, input logic b,
                     input logic [A-1:0] ad);
    vec_t v;
    v = '{r, rq, lk, g, rv, b, ad};
    vt.push_back(v);
  endtask

  initial begin
    for (int i = 0; i < (1 << A); i++) rom[i] = D'(i * 5 + (i >> 4));
    for (int i = 0; i < LAT; i++) begin
      qtag.push_back(-1);
      qaddr.push_back('0);
    end
    m_ptr = 0; m_own = -1; m_last = '0;
    addr_arr[0] = 9'd5;
    addr_arr[1] = 9'd100;
    addr_arr[2] = 9'd37;
    addr_arr[3] = 9'd300;

`ifdef SPRITE_ARB_PRIO0_EN
    add(0, 4'b1011, 0, 4'b0001, 4'b0000, 0, 5);
    add(0, 4'b1011, 0, 4'b0001, 4'b0001, 1, 5);
    add(0, 4'b1011, 0, 4'b0001, 4'b0001, 1, 5);
    add(0, 4'b1011, 0, 4'b0001, 4'b0001, 1, 5);
    add(0, 4'b1010, 0, 4'b0010, 4'b0001, 1, 100);
    add(0, 4'b1010, 0, 4'b1000, 4'b0010, 1, 300);
    add(0, 4'b1010, 0, 4'b0010, 4'b1000, 1, 100);
    add(0, 4'b1010, 0, 4'b1000, 4'b0010, 1, 300);
    add(0, 4'b0000, 0, 4'b0000, 4'b1000, 1, 300);
    add(0, 4'b0000, 0, 4'b0000, 4'b0000, 0, 300);
`else
    add(0, 4'b1111, 0, 4'b0001, 4'b0000, 0, 5);
    add(0, 4'b1111, 0, 4'b0010, 4'b0001, 1, 100);
    add(0, 4'b1111, 0, 4'b0100, 4'b0010, 1, 37);
    add(0, 4'b1111, 0, 4'b1000, 4'b0100, 1, 300);
    add(0, 4'b1111, 0, 4'b0001, 4'b1000, 1, 5);
    add(0, 4'b0000, 0, 4'b0000, 4'b0001, 1, 5);
    add(0, 4'b0000, 0, 4'b0000, 4'b0000, 0, 5);
    add(0, 4'b0100, 0, 4'b0100, 4'b0000, 0, 37);
    add(0, 4'b0000, 0, 4'b0000, 4'b0100, 1, 37);
    add(0, 4'b0000, 0, 4'b0000, 4'b0000, 0, 37);
    add(0, 4'b1111, 0, 4'b1000, 4'b0000, 0, 300);
    add(0, 4'b1111, 0, 4'b0001, 4'b1000, 1, 5);
    add(0, 4'b1111, 4'b0010, 4'b0010, 4'b0001, 1, 100);
    add(0, 4'b1111, 4'b0010, 4'b0010, 4'b0010, 1, 100);
    add(0, 4'b1111, 4'b0010, 4'b0010, 4'b0010, 1, 100);
    add(0, 4'b1111, 4'b0000, 4'b0010, 4'b0010, 1, 100);
    add(0, 4'b1111, 4'b0000, 4'b0100, 4'b0010, 1, 37);
    add(0, 4'b0000, 0, 4'b0000, 4'b0100, 1, 37);
    add(0, 4'b0000, 0, 4'b0000, 4'b0000, 0, 37);
    add(0, 4'b1111, 4'b0100, 4'b1000, 4'b0000, 0, 300);
    add(0, 4'b0001, 4'b0100, 4'b0001, 4'b1000, 1, 5);
    add(0, 4'b0000, 0, 4'b0000, 4'b0001, 1, 5);
    add(0, 4'b0000, 0, 4'b0000, 4'b0000, 0, 5);
    add(0, 4'b0010, 4'b0010, 4'b0010, 4'b0000, 0, 100);
    add(0, 4'b0101, 4'b0010, 4'b0000, 4'b0010, 1, 100);
    add(0, 4'b0101, 4'b0010, 4'b0000, 4'b0000, 1, 100);
    add(0, 4'b0101, 4'b0000, 4'b0000, 4'b0000, 1, 100);
    add(0, 4'b0101, 4'b0000, 4'b0100, 4'b0000, 0, 37);
    add(0, 4'b0000, 0, 4'b0000, 4'b0100, 1, 37);
    add(0, 4'b0000, 0, 4'b0000, 4'b0000, 0, 37);
`endif

    @(negedge clk);
    apply(1, '0, '0);
    tick();
    apply(1, 4'b1111, '0);
    chk("rst_gnt", 32'(bus.gnt), 0);
    chk("rst_rv", 32'(bus.rd_valid), 0);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_addr", 32'(bus.rom_address), 0);
    tick();

    for (int i = 0; i < vt.size(); i++) begin
      apply(vt[i].r, vt[i].req, vt[i].lock);
      chk("tbl_gnt", 32'(bus.gnt), 32'(vt[i].gnt));
      chk("tbl_rv", 32'(bus.rd_valid), 32'(vt[i].rv));
      chk("tbl_busy", 32'(bus.busy), 32'(vt[i].busy));
      chk("tbl_addr", 32'(bus.rom_address), 32'(vt[i].addr));
      if (i > 0 && vt[i].rv != 0)
        chk("tbl_data", 32'(bus.rd_data), 32'(rom[vt[i-1].addr]));
      tick();
    end

    // Reset one cycle after a grant: the read never returns.
    apply(0, 4'b0010, '0);
    chk("mf_gnt", 32'(bus.gnt), 32'(4'b0010));
    tick();
    apply(1, 4'b0010, 4'b0010);
    chk("mf_rst_gnt", 32'(bus.gnt), 0);
    chk("mf_rst_rv", 32'(bus.rd_valid), 0);
    tick();
    apply(0, 4'b1100, '0);
    chk("mf_first", 32'(bus.gnt), 32'(4'b0100));
    chk("mf_rv", 32'(bus.rd_valid), 0);
    chk("mf_busy", 32'(bus.busy), 0);
    tick();
    apply(0, '0, '0);
    chk("mf_rv2", 32'(bus.rd_valid), 32'(4'b0100));
    tick();

    // Reset while locked releases ownership.
    apply(0, 4'b0001, 4'b0001);
    chk("rl_gnt", 32'(bus.gnt), 32'(4'b0001));
    tick();
    apply(1, 4'b0001, 4'b0001);
    tick();
    apply(0, 4'b0010, '0);
    chk("rl_free", 32'(bus.gnt), 32'(4'b0010));
    chk("rl_busy", 32'(bus.busy), 0);
    tick();
    apply(0, '0, '0);
    tick();

    // Idle: address holds the last grant.
    for (int i = 0; i < 10; i++) begin
      apply(0, '0, '0);
      chk("idle_gnt", 32'(bus.gnt), 0);
      chk("idle_rv", 32'(bus.rd_valid), 0);
      chk("idle_busy", 32'(bus.busy), 0);
      chk("idle_addr", 32'(bus.rom_address), 32'(9'd100));
      tick();
    end

    // Random traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      logic r;
      logic [N-1:0] rq, lk;
      r  = ($urandom_range(0, 49) == 0);
      rq = N'($urandom);
      lk = N'($urandom) & N'($urandom);
      for (int i = 0; i < N; i++)
        if ($urandom_range(0, 3) == 0) addr_arr[i] = A'($urandom);
      apply(r, rq, lk);
      chk("rnd_gnt", 32'(bus.gnt), 32'(exp_gnt));
      chk("rnd_rv", 32'(bus.rd_valid), 32'(exp_rv));
      chk("rnd_busy", 32'(bus.busy), 32'(exp_busy));
      if (!r) chk("rnd_addr", 32'(bus.rom_address), 32'(exp_addr));
      if (exp_rv != 0)
        chk("rnd_data", 32'(bus.rd_data), 32'(exp_data));
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/sprite_rom_arbiter.md
Name: sprite_rom_arbiter

Overview:
Shares one synchronous palettized sprite ROM (tile/brickwall/tank index ROM, 1-cycle-registered read) among NUM_REQ pixel/sprite requesters on the vga_clk domain. Performs round-robin arbitration with optional burst lock, drives the ROM address, and returns each read's data to the owning requester with a one-hot valid pulse. Sits between the per-object draw engines and the ROM; the palette lookup stays downstream of rd_data.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
ADDR_W, 9, ROM address width
DATA_W, 3, ROM word (palette index) width
ROM_LAT, 1, ROM read latency in vga_clk cycles (1..3)

Ports:
vga_clk  input  1  sole clock, all state on rising edge
reset  input  1  synchronous, active-high
req  input  NUM_REQ  per-requester read request, level
req_addr  input  NUM_REQ*ADDR_W  packed addresses, requester i at [i*ADDR_W +: ADDR_W]
req_lock  input  NUM_REQ  requester i keeps ownership after its current grant
gnt  output  NUM_REQ  one-hot grant, combinational, same cycle as accepted req
rom_address  output  ADDR_W  address to ROM
rom_q  input  DATA_W  ROM data, valid ROM_LAT cycles after address
rd_valid  output  NUM_REQ  one-hot, read data for requester i valid this cycle
rd_data  output  DATA_W  ROM data, qualified by rd_valid
busy  output  1  a read is in flight or ownership is locked

Behaviour:
- Handshake: requester holds req=1 and stable req_addr until it sees gnt[i]=1 at a rising edge; each cycle with gnt[i]=1 is exactly one accepted read. Keeping req high after a grant requests another read.
- Throughput: one read per cycle; no bubbles between back-to-back grants.
- gnt is a one-hot function of req, rr_ptr, lock_owner; at most one bit is set; it is all-zero when req==0 or reset==1.
- rom_address = req_addr of the granted requester; holds its last granted value when gnt==0 (registered copy, reset 0).
- Round-robin: search starts at rr_ptr and wraps NUM_REQ-1 -> 0. On a grant to w, rr_ptr <= (w+1) mod NUM_REQ. With no grant, rr_ptr holds.
- States: ARB (lock_owner invalid) and LOCKED (lock_owner = w).
  - ARB -> LOCKED when gnt[w]=1 and req_lock[w]=1.
  - In LOCKED only w can be granted; others wait even if w is idle.
  - LOCKED -> ARB at the edge where req_lock[w]=0. A final grant in that same cycle is still issued to w.
  - rr_ptr is not advanced while LOCKED. On the exit edge it becomes (w+1) mod NUM_REQ.
- Return path: ROM_LAT-deep shift register of {valid, one-hot tag}. rd_valid = tag & valid at the tail, exactly ROM_LAT cycles after the granting cycle. rd_data = rom_q, passed through combinationally.
- busy = any valid bit in the pipeline OR state==LOCKED.
- Reset (any time, including mid-burst or with reads in flight):
  - all pipeline valids, rd_valid, lock_owner and rr_ptr cleared to 0; state ARB; rom_address 0.
  - in-flight reads are discarded, never returned.
  - first grant after reset goes to the lowest-index active requester.
- Simultaneous events:
  - req dropping in the same cycle gnt would assert means no grant (gnt is combinational from the current req).
  - req_lock asserted by a non-owner is ignored.

Optional Feature:
SPRITE_ARB_PRIO0_EN: when defined, requester 0 (the live VGA background fetch) has absolute priority in ARB state. Any req[0]=1 wins, and rr_ptr does not advance on its grants. LOCKED state still blocks requester 0 until unlock. When undefined, requester 0 is an ordinary round-robin participant.

Test Plan:
- Reset then req=4'b1111, all addrs distinct, held high -> gnt 0001,0010,0100,1000,0001 on consecutive cycles; rd_valid follows each gnt by ROM_LAT; rd_data matches ROM contents.
- req=4'b0100 only with req_addr[2]=9'd37 -> gnt=0100 same cycle, rom_address=37, rd_valid=0100 one cycle later (ROM_LAT=1), busy high for one cycle.
- Req 1 asserts req_lock for 3 grants while req=4'b1111 -> gnt=0010 x3 with others starved. Unlock cycle still grants 1; next grant goes to requester 2.
- reset pulsed one cycle after a grant with ROM_LAT=3 -> no rd_valid pulse ever appears for that read; rr_ptr=0, busy=0 the cycle after reset.
- With SPRITE_ARB_PRIO0_EN, req=4'b1011 held -> requester 0 granted every cycle. Drop req[0] -> next grants 1,3,1,3.
- req=0 for 10 cycles -> gnt=0, rd_valid=0, rom_address holds last granted value, busy=0.
